sequencer_detector: RTL and testbench
=====================================

# sequencer_detector

Serial bit-pattern detector. It samples a 1-bit input stream once per clock and emits a one-cycle pulse whenever the most recent PATTERN_LEN samples equal PATTERN. Overlapping occurrences are detected by default. It sits on a serial data path as a framing or sync-word flag generator; the default configuration detects 1011.

## Interface
- PATTERN_LEN, default 4: pattern length in bits, legal range 2..32.
- PATTERN, default 4'b1011: target sequence, width PATTERN_LEN. The MSB is the first bit received and the LSB the last.
- OVERLAP, default 1: 1 lets a match's suffix seed the next match; 0 restarts matching from empty after every match.
- clk  input  1  single clock; all state changes on its rising edge.
- rstn  input  1  reset, synchronous and active-high. rstn=1 at a rising clk edge resets the block. The port keeps the codebase name rstn despite active-high polarity.
- in  input  1  serial data bit, sampled on every rising clk edge while not in reset.
- out  output  1  registered match pulse.

## Operation
- Internal state is the match progress k, in 0..PATTERN_LEN-1. k is the length of the longest suffix of sampled bits that equals a prefix of PATTERN.
- This is a KMP-style automaton, implemented as an explicit FSM or as a shift register plus prefix compare. For the defaults the states are:
  - S0: no match, k=0.
  - S1: "1" seen.
  - S10: "10" seen.
  - S101: "101" seen.
- Default transitions:
  - S0: in=1 -> S1; in=0 -> S0.
  - S1: in=0 -> S10; in=1 -> S1.
  - S10: in=1 -> S101; in=0 -> S0.
  - S101: in=1 -> match; in=0 -> S10.
- On a match with OVERLAP=1, the next k is the length of the longest proper border of PATTERN (1 for 1011, so next state S1).
- On a match with OVERLAP=0, the next k is 0.
- A sample that extends the current prefix increments k. Any other sample falls back to the longest border consistent with that sample, as for a mismatch in standard KMP.
- Fallback/border values are computed at elaboration from PATTERN, not hard-coded.
- out=1 in the cycle after the edge that sampled the final pattern bit; otherwise out=0.
- out is a flop output with no combinational path from in.
- Reset:
  - State: k=0 and out=0 on the reset edge.
  - Partial progress: discarded entirely.
  - First sample: the first sample after rstn deasserts starts a fresh match.
- A reset edge coinciding with the final pattern bit gives priority to reset: no pulse.
- Back-to-back matches are allowed: out may be high on consecutive cycles only if PATTERN permits it (e.g. PATTERN=2'b11 with input 1,1,1 pulses on the 2nd and 3rd samples).

## Timing
- Latency: 1 clock. If the final pattern bit is sampled at edge N, out is high from edge N until edge N+1.
- Pulse width: exactly one cycle per match.
- Reset value: out=0 from the first reset edge onward. Before the first reset edge, out is undefined.
- Throughput: one input bit per cycle; no stall or handshake.
- in must meet setup/hold to clk. Stimulus is driven just after the rising edge.

## Test plan
- Reset and defaults:
  - Stimulus: hold rstn=1 for 5 edges with in=0.
  - Response: out=0 throughout and k=0.
- Directed stream, defaults:
  - Stimulus: after reset release, drive 1,0,1,1,0,0,1,1,0,1,1, one bit per edge.
  - Response: out pulses exactly twice, in the cycle after the 4th bit and after the 11th bit; 0 elsewhere.
- Overlap:
  - Stimulus: 1,0,1,1,0,1,1 with OVERLAP=1.
  - Response: pulses after bits 4 and 7.
  - Stimulus: the same sequence with OVERLAP=0.
  - Response: a single pulse after bit 4.
- Fallback paths:
  - Stimulus: 1,1,0,1,1.
  - Response: one pulse after bit 5 (tests S1 self-loop).
  - Stimulus: 1,0,1,0,1,1.
  - Response: one pulse after bit 6 (tests S101 -> S10 on 0).
- Reset mid-pattern:
  - Stimulus: 1,0,1, then rstn=1 for one edge, then 1.
  - Response: no pulse.
  - Stimulus: 1,0,1,1 with rstn=1 on the 4th bit's edge.
  - Response: no pulse.
- Random regression:
  - Stimulus: 10k random bits with random gaps.
  - Response: out matches a reference model (sliding-window compare against PATTERN, delayed 1 cycle) on every cycle.

Source files
------------

// File: rtl/sequencer_detector.sv
// rtl/sequencer_detector.sv - serial bit-pattern detector, one-cycle match pulse
//
// Purpose: watches a 1-bit stream and pulses `out` for one cycle after the
// sample that completes PATTERN (MSB is the first bit received). The match
// progress k is a KMP automaton. Its next-state table is built at
// elaboration from PATTERN, so any pattern of 2..32 bits works without
// editing the logic.
//
// Ports:
//   clk   in   1  rising-edge clock
//   rstn  in   1  synchronous reset, active-high (name kept from codebase)
//   in    in   1  serial data bit, sampled every rising edge
//   out   out  1  registered match pulse
module sequencer_detector #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter bit                     OVERLAP     = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic in,
  output logic out
);

  localparam int KW    = $clog2(PATTERN_LEN);
  localparam int TBL_W = 2 * PATTERN_LEN * KW;

  // Pattern bit in arrival order: index 0 is the first bit received.
  function automatic logic pbit(input int i);
    return PATTERN[PATTERN_LEN-1-i];
  endfunction

  // Longest proper border of the whole pattern; this is where matching
  // resumes after a hit when overlapping occurrences are allowed.
  function automatic int full_border();
    int  res;
    logic ok;
    res = 0;
    for (int j = PATTERN_LEN - 1; j >= 1; j--) begin
      if (res == 0) begin
        ok = 1'b1;
        for (int m = 0; m < j; m++) begin
          if (pbit(m) != pbit(PATTERN_LEN - j + m)) ok = 1'b0;
        end
        if (ok) res = j;
      end
    end
    return res;
  endfunction

  // Entry {k, bit} holds the next k: the longest suffix of
  // (prefix of length k, then bit) that is itself a prefix of PATTERN.
  // A completed match resumes at the border, or at 0 without overlap.
  function automatic logic [TBL_W-1:0] build_tbl();
    logic [TBL_W-1:0] t;
    int               nk;
    int               pos;
    logic             ok;
    logic             bl;
    logic             sym;
    t = '0;
    for (int k = 0; k < PATTERN_LEN; k++) begin
      for (int b = 0; b < 2; b++) begin
        bl = (b != 0);
        nk = 0;
        if ((k == PATTERN_LEN - 1) && (bl == pbit(PATTERN_LEN - 1))) begin
          nk = OVERLAP ? full_border() : 0;
        end else begin
          for (int j = k + 1; j >= 1; j--) begin
            if (nk == 0) begin
              ok = 1'b1;
              for (int m = 0; m < j; m++) begin
                pos = k + 1 - j + m;
                sym = (pos == k) ? bl : pbit(pos);
                if (pbit(m) != sym) ok = 1'b0;
              end
              if (ok) nk = j;
            end
          end
        end
        t[(k*2+b)*KW +: KW] = nk[KW-1:0];
      end
    end
    return t;
  endfunction

  localparam logic [TBL_W-1:0] NEXT_TBL = build_tbl();
  localparam logic [KW-1:0]    LAST_K   = KW'(PATTERN_LEN - 1);

  logic [KW-1:0] k_q, k_d;
  logic          out_q, out_d;
  logic [KW:0]   idx;

  always_comb begin
    idx   = {k_q, in};
    k_d   = NEXT_TBL[32'(idx)*KW +: KW];
    // A hit is the last pattern bit arriving while one bit short of it.
    out_d = (k_q == LAST_K) && (in == PATTERN[0]);
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      k_q   <= '0;
      out_q <= 1'b0;
    end else begin
      k_q   <= k_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_sequencer_detector.sv
// tb/tb_sequencer_detector.sv - directed and random bench for sequencer_detector
module tb_sequencer_detector;

  logic clk = 1'b0;
  logic rstn;
  logic din;
  logic out_def, out_no, out_11;

  always #5 clk = ~clk;

  sequencer_detector dut_def (
    .clk(clk), .rstn(rstn), .in(din), .out(out_def)
  );

  sequencer_detector #(.OVERLAP(1'b0)) dut_no (
    .clk(clk), .rstn(rstn), .in(din), .out(out_no)
  );

  sequencer_detector #(.PATTERN_LEN(2), .PATTERN(2'b11)) dut_11 (
    .clk(clk), .rstn(rstn), .in(din), .out(out_11)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one sample, let the edge take it, and settle just after the edge.
  task automatic step(input logic b, input logic r);
    din  = b;
    rstn = r;
    @(posedge clk);
    #1;
  endtask

  // One reset edge, then the bit string; rs marks edges with reset asserted.
  task automatic run_seq(input string tag, input string bits, input string rs,
                         input string e_def, input string e_no, input string e_11);
    step(1'b0, 1'b1);
    chk({tag, "/rst_def"}, out_def, 1'b0);
    chk({tag, "/rst_no"},  out_no,  1'b0);
    chk({tag, "/rst_11"},  out_11,  1'b0);
    for (int i = 0; i < bits.len(); i++) begin
      step(bits[i] == "1", rs[i] == "1");
      chk($sformatf("%s/def[%0d]", tag, i + 1), out_def, e_def[i] == "1");
      chk($sformatf("%s/no[%0d]",  tag, i + 1), out_no,  e_no[i]  == "1");
      chk($sformatf("%s/p11[%0d]", tag, i + 1), out_11,  e_11[i]  == "1");
    end
  endtask

  initial begin
    logic        b;
    logic        r;
    logic [31:0] hist;
    int          cnt_ov;
    int          cnt_no;
    logic        e_def, e_no, e_11;

    din  = 1'b0;
    rstn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1);
      chk($sformatf("reset_def[%0d]", i), out_def, 1'b0);
      chk($sformatf("reset_no[%0d]",  i), out_no,  1'b0);
      chk($sformatf("reset_11[%0d]",  i), out_11,  1'b0);
    end

    run_seq("stream",  "10110011011", "00000000000",
            "00010000001", "00010000001", "00010001001");
    run_seq("overlap", "1011011", "0000000",
            "0001001", "0001000", "0001001");
    run_seq("s1_loop", "11011", "00000",
            "00001", "00001", "01001");
    run_seq("s101_0",  "101011", "000000",
            "000001", "000001", "000001");
    run_seq("rst_mid", "1011", "0010",
            "0000", "0000", "0000");
    run_seq("rst_end", "1011", "0001",
            "0000", "0000", "0000");
    run_seq("b2b",     "111", "000",
            "000", "000", "011");

    // Random regression against a sliding-window reference.
    step(1'b0, 1'b1);
    hist   = '0;
    cnt_ov = 0;
    cnt_no = 0;
    for (int i = 0; i < 10000; i++) begin
      r = ($urandom_range(0, 63) == 0);
      b = 1'($urandom_range(0, 1));
      step(b, r);
      if (r) begin
        cnt_ov = 0;
        cnt_no = 0;
        e_def  = 1'b0;
        e_no   = 1'b0;
        e_11   = 1'b0;
      end else begin
        hist = {hist[30:0], b};
        if (cnt_ov < 64) cnt_ov++;
        if (cnt_no < 64) cnt_no++;
        e_def = (cnt_ov >= 4) && (hist[3:0] == 4'b1011);
        e_no  = (cnt_no >= 4) && (hist[3:0] == 4'b1011);
        if (e_no) cnt_no = 0;
        e_11  = (cnt_ov >= 2) && (hist[1:0] == 2'b11);
      end
      chk($sformatf("rand_def[%0d]", i), out_def, e_def);
      chk($sformatf("rand_no[%0d]",  i), out_no,  e_no);
      chk($sformatf("rand_11[%0d]",  i), out_11,  e_11);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
